// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants, FSM state type and frame-width helpers
package decoder_pkg;
    localparam int WORD_W = 32;
    localparam int CODE_W = 5;
    typedef enum logic {IDLE, SEND} state_e;
    function automatic bit legal_out_w(input int w);
        return w inside {1, 2, 4, 8, 16, 32};
    endfunction
    function automatic int frame_idx_w(input int w);
        return (WORD_W / w > 1) ? $clog2(WORD_W / w) : 1;
    endfunction
endpackage

// File: rtl/decoder_frame_slice.sv
// decoder_frame_slice: one OUT_W-bit window of the one-hot word selected by a frame index
module decoder_frame_slice
    import decoder_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [CODE_W-1:0]             code_i,
    input  logic                          en_i,
    input  logic [frame_idx_w(OUT_W)-1:0] idx_i,
    output logic [OUT_W-1:0]              slice_o
);
    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign slice_o[i] = en_i && (int'(code_i) == int'(idx_i) * OUT_W + i);
    end
endmodule

// File: rtl/decoder_32bit_mcc.sv
// decoder_32bit_mcc: 5-to-32 decoder streaming its one-hot word as NFRAMES handshaked frames
module decoder_32bit_mcc
    import decoder_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CODE_W-1:0]             in_code,
    input  logic                          in_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_frame,
    output logic [frame_idx_w(OUT_W)-1:0] out_idx,
    output logic                          out_first,
    output logic                          out_last
);
    localparam int NFRAMES = WORD_W / OUT_W;
    localparam int IDX_W = frame_idx_w(OUT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFRAMES - 1);

    if (!legal_out_w(OUT_W)) begin : g_bad_out_w
        $error("OUT_W must be one of 1, 2, 4, 8, 16, 32");
    end

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              en_q, en_d;
    logic [IDX_W-1:0]  f_q, f_d;
    logic              at_last, accept, fire;

    assign at_last = f_q == LAST_IDX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            en_q    <= 1'b0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            en_q    <= en_d;
            f_q     <= f_d;
        end
    end

    // A new word may load on the same edge that retires the last frame, so words abut without a bubble.
    always_comb begin
        accept  = in_valid && in_ready;
        fire    = out_valid && out_ready;
        state_d = accept ? SEND : (fire && at_last) ? IDLE : state_q;
        code_d  = accept ? in_code : code_q;
        en_d    = accept ? in_en : en_q;
        f_d     = accept ? '0 : (fire && !at_last) ? f_q + IDX_W'(1) : f_q;
    end

    always_comb begin
        out_valid = state_q == SEND;
        in_ready  = (state_q == IDLE) || (out_valid && at_last && out_ready);
        out_idx   = f_q;
        out_first = out_valid && (f_q == '0);
        out_last  = out_valid && at_last;
    end

    decoder_frame_slice #(.OUT_W(OUT_W)) u_slice (
        .code_i  (code_q),
        .en_i    (en_q && state_q == SEND),
        .idx_i   (f_q),
        .slice_o (out_frame)
    );
endmodule

// File: tb/tb_decoder_32bit_mcc.sv
// tb_decoder_32bit_mcc: vector table, directed corner sequences and random traffic against a word-queue model
module tb_decoder_32bit_mcc;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, in_en = 1'b0, out_valid, out_ready = 1'b1, out_first, out_last;
    logic [4:0]  in_code = '0;
    logic [7:0]  out_frame;
    logic [1:0]  out_idx;
    logic        v32 = 1'b0, r32, e32 = 1'b0, ov32, or32 = 1'b1, ofi32, ola32;
    logic [4:0]  c32 = '0;
    logic [31:0] of32;
    logic [0:0]  oi32;

    decoder_32bit_mcc #(.OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
        .out_idx(out_idx), .out_first(out_first), .out_last(out_last)
    );
    decoder_32bit_mcc #(.OUT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_code(c32),
        .in_en(e32), .out_valid(ov32), .out_ready(or32), .out_frame(of32),
        .out_idx(oi32), .out_first(ofi32), .out_last(ola32)
    );

    int total = 0, bad = 0;
    logic [31:0] q8[$], q32[$];
    int c8 = 0;
    logic [31:0] pend8 = '0, pend32 = '0;
    logic acc8 = 1'b0, acc32 = 1'b0;

    typedef struct {
        logic [4:0]  code;
        logic        en;
        logic [31:0] word;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // Model: a queue of whole 32-bit words; the head word is shown one frame at a time.
    task automatic mon8();
        logic rdy;
        if (!rst_n) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_frame", out_frame, 0);
            chk("rst_idx", out_idx, 0);
            chk("rst_first_last", {out_first, out_last}, 0);
            q8.delete();
            c8 = 0;
            acc8 = 1'b0;
            return;
        end
        rdy = (q8.size() == 0) || (c8 == 3 && out_ready);
        chk("valid", out_valid, q8.size() != 0);
        chk("in_ready", in_ready, rdy);
        if (q8.size() != 0) begin
            chk("frame", out_frame, (q8[0] >> (c8 * 8)) & 32'hff);
            chk("idx", out_idx, c8);
            chk("first", out_first, c8 == 0);
            chk("last", out_last, c8 == 3);
            if (out_ready) begin
                c8++;
                if (c8 == 4) begin
                    void'(q8.pop_front());
                    c8 = 0;
                end
            end
        end
        acc8 = in_valid && rdy;
        if (acc8) q8.push_back(pend8);
    endtask

    task automatic mon32();
        logic rdy;
        if (!rst_n) begin
            chk("rst32_valid", ov32, 0);
            chk("rst32_frame", of32, 0);
            q32.delete();
            acc32 = 1'b0;
            return;
        end
        rdy = (q32.size() == 0) || or32;
        chk("valid32", ov32, q32.size() != 0);
        chk("in_ready32", r32, rdy);
        if (q32.size() != 0) begin
            chk("frame32", of32, q32[0]);
            chk("idx32", oi32, 0);
            chk("first_last32", {ofi32, ola32}, 2'b11);
            if (or32) void'(q32.pop_front());
        end
        acc32 = v32 && rdy;
        if (acc32) q32.push_back(pend32);
    endtask

    task automatic tick();
        #2;
        mon8();
        mon32();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [4:0] code, input logic en, input logic [31:0] word);
        in_valid = 1'b1;
        in_code = code;
        in_en = en;
        pend8 = word;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (acc8) break;
        end
        chk("send8_accept", acc8, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int nv, phase;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_frame", out_frame, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_idx", out_idx, 0);

        tv = '{'{5'd5, 1'b1, 32'h0000_0020}, '{5'd31, 1'b1, 32'h8000_0000}, '{5'd7, 1'b0, 32'h0},
               '{5'd0, 1'b1, 32'h0000_0001}, '{5'd17, 1'b1, 32'h0002_0000}, '{5'd12, 1'b1, 32'h0000_1000},
               '{5'd9, 1'b1, 32'h0000_0200}, '{5'd3, 1'b0, 32'h0}};
        for (int i = 0; i < 8; i++) begin
            send8(tv[i].code, tv[i].en, tv[i].word);
            chk("tab_frame0", out_frame, tv[i].word & 32'hff);
            chk("tab_first", out_first, 1);
            repeat (4) tick();
        end

        send8(5'd12, 1'b1, 32'h1000);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_idx", out_idx, 1);
            chk("bp_frame", out_frame, 8'h10);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        repeat (4) tick();

        in_valid = 1'b1;
        in_code = 5'd0;
        in_en = 1'b1;
        pend8 = 32'h1;
        nv = 0;
        phase = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (acc8 && phase == 0) begin
                in_code = 5'd17;
                pend8 = 32'h0002_0000;
                phase = 1;
            end else if (acc8 && phase == 1) begin
                in_valid = 1'b0;
                phase = 2;
            end
            nv += int'(out_valid);
        end
        chk("b2b_valid_cycles", nv, 8);
        chk("b2b_second_taken", phase, 2);

        send8(5'd9, 1'b1, 32'h200);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_frame", out_frame, 0);
        chk("async_rst_idx", out_idx, 0);
        tick();
        tick();
        rst_n = 1'b1;
        send8(5'd3, 1'b1, 32'h8);
        chk("post_rst_frame", out_frame, 8'h08);
        repeat (4) tick();

        for (int n = 0; n < 400; n++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if (!in_valid) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_code = 5'($urandom);
                in_en = $urandom_range(0, 3) != 0;
                pend8 = in_en ? 32'h1 << in_code : 32'h0;
            end
            tick();
            if (acc8) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("rand_drained", q8.size(), 0);

        v32 = 1'b1;
        c32 = 5'd5;
        e32 = 1'b1;
        pend32 = 32'h20;
        tick();
        chk("w32_accept", acc32, 1);
        v32 = 1'b0;
        chk("w32_frame", of32, 32'h20);
        chk("w32_first_last", {ofi32, ola32}, 2'b11);
        tick();
        v32 = 1'b1;
        c32 = 5'd0;
        pend32 = 32'h1;
        tick();
        c32 = 5'd17;
        pend32 = 32'h0002_0000;
        chk("w32_b2b_a", of32, 32'h1);
        tick();
        v32 = 1'b0;
        chk("w32_b2b_b", of32, 32'h0002_0000);
        tick();
        chk("w32_idle", ov32, 0);
        for (int n = 0; n < 150; n++) begin
            or32 = $urandom_range(0, 3) != 0;
            if (!v32) begin
                v32 = $urandom_range(0, 1) == 1;
                c32 = 5'($urandom);
                e32 = $urandom_range(0, 1) == 1;
                pend32 = e32 ? 32'h1 << c32 : 32'h0;
            end
            tick();
            if (acc32) v32 = 1'b0;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decoder_32bit_mcc.md
Name: decoder_32bit_mcc

Overview:
- Multi-clock-cycle 5-to-32 decoder. It is the inverse of the team's combinational 32-bit encoder.
- Accepts a 5-bit code plus an enable bit over a valid/ready handshake.
- Emits the 32-bit one-hot word serially, as NFRAMES frames of OUT_W bits each, so that downstream garbled-circuit stages see a narrow per-cycle datapath.

Parameters:
- OUT_W, 8, frame width in bits. Legal values are 1, 2, 4, 8, 16, 32; any other value is an elaboration error.
- NFRAMES, 32/OUT_W, derived localparam. It must not be overridden.
- IDX_W, max(1, clog2(NFRAMES)), derived localparam giving the width of the frame index.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code/in_en are valid.
- in_ready  output  1  block accepts input this cycle.
- in_code  input  5  index of the bit to set, 0..31.
- in_en  input  1  1 = one-hot of in_code; 0 = all-zero word.
- out_valid  output  1  out_frame is valid.
- out_ready  input  1  downstream accepts the frame.
- out_frame  output  OUT_W  decoded word bits [out_idx*OUT_W +: OUT_W].
- out_idx  output  IDX_W  current frame number, 0..NFRAMES-1.
- out_first  output  1  high when out_idx==0 and out_valid.
- out_last  output  1  high when out_idx==NFRAMES-1 and out_valid.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state=IDLE, code_q=0, en_q=0, frame counter f=0.
  - out_valid=0, out_frame=0, out_first=0, out_last=0, out_idx=0.
  - in_ready=1 while rst_n is high and state==IDLE.
- FSM states: IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: code_q<=in_code, en_q<=in_en, f<=0, go to SEND.
- SEND:
  - out_valid=1.
  - out_frame[i] = en_q && (code_q == f*OUT_W+i), for i in 0..OUT_W-1.
  - out_idx=f.
- Frame advance: on out_valid&out_ready with f<NFRAMES-1, f<=f+1.
- Last-frame handshake, on out_valid&out_ready with f==NFRAMES-1:
  - If in_valid: load new code/en, f<=0, stay in SEND. There is no bubble.
  - Else: go to IDLE.
- in_ready = (state==IDLE) | (state==SEND & f==NFRAMES-1 & out_ready). This is the only combinational input-to-output path.
- Latency: the first frame is valid the cycle after acceptance. A word occupies exactly NFRAMES handshaked cycles.
- Throughput: one frame per cycle when out_ready=1, including across word boundaries.
- Backpressure: while out_valid & !out_ready, out_frame, out_idx, out_first and out_last hold stable, and in_ready=0.
- in_en=0: NFRAMES all-zero frames are still emitted, so the frame count is independent of data.
- in_code values are 0..31 only. Every code is legal.
- Exactly one bit is set across all frames of a word when en_q=1, and zero bits when en_q=0.
- NFRAMES=1 (OUT_W=32):
  - f stays 0; out_first=out_last=1 whenever out_valid.
  - Throughput is one word per cycle.
- Reset mid-word: the word is discarded, outputs return to reset values immediately, and the block is in IDLE after release.
- in_valid while in_ready=0 is ignored. Upstream holds its data; no capture occurs.
- All outputs except in_ready are driven from registers only (code_q, en_q, f, state).

Decomposition:
- Package decoder_pkg holds:
  - WORD_W=32 and CODE_W=5 constants.
  - The state enum {IDLE, SEND}.
  - A function legal_out_w(w) used in an elaboration-time assertion.
- Sub-module decoder_frame_slice (combinational, parameter OUT_W):
  - Inputs code, en, frame index; output the OUT_W-bit slice.
  - Instantiated once. It is reusable by other multi-cycle benchmarks.
- The top level holds the FSM, frame counter, capture registers and handshake.

Test Plan:
1. Reset, with rst_n low 3 cycles then high → out_valid=0, out_frame=0x00, in_ready=1, out_idx=0.
2. OUT_W=8, in_code=5, in_en=1, out_ready=1 →
   - out_frame 0x20,0x00,0x00,0x00 on 4 consecutive cycles starting 1 cycle after accept.
   - out_first only on frame 0; out_last only on frame 3.
3. in_code=31, en=1 → frames 0x00,0x00,0x00,0x80. Then in_code=7, en=0 → four 0x00 frames, out_valid high 4 cycles.
4. Backpressure: in_code=12, out_ready dropped for 3 cycles at frame 1 →
   - out_idx holds at 1, out_frame holds at 0x10, in_ready=0.
   - Resumes with frames 2 and 3 = 0x00.
5. Back-to-back: codes 0 then 17 presented continuously, out_ready=1 →
   - 8 consecutive valid cycles, frames 0x01,0,0,0,0,0,0x02,0.
   - in_ready pulses on frame 3 of the first word.
6. Reset mid-word (after frame 1 of code 9) → out_valid falls asynchronously. After release the next code 3 yields 0x08,0,0,0. Repeat tests 2 and 5 with OUT_W=32: one cycle per word, out_frame=0x00000020, out_first=out_last=1.
